// File: rtl/mov_buf.sv
// mov_buf: a WIDTH-bit, DEPTH-entry elastic FIFO with valid/ready handshakes on
// both sides. When bypass_en is set and the buffer is empty, a word can pass
// from in_data to out_data in the same cycle. If the consumer is stalled, that
// word is stored instead and presented on the next cycle. Bypass never
// overtakes stored data because it is only active while the buffer is empty.
module mov_buf #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bypass_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW:0]      count
);

    // Pointer and counter step constants, sized to their targets.
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(0);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    // Storage and bookkeeping state.
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;

    // Decoded per-cycle status and events.
    logic empty_s;
    logic full_s;
    logic thru_s;
    logic push_s;
    logic pop_s;

    // Status flags and handshake events, derived from the current occupancy.
    always_comb begin
        empty_s = (count_r == CNT_ZERO);
        full_s  = (count_r == CNT_FULL);
        // A word moving straight through must not also be stored. Pushes are
        // gated on ~full only, even when a pop happens in the same cycle, so
        // in_ready never depends on out_ready.
        thru_s  = bypass_en & empty_s & in_valid & out_ready;
        push_s  = in_valid & ~full_s & ~thru_s;
        pop_s   = ~empty_s & out_ready;
    end

    // Output-side muxing: stored data has priority, then bypass, else zero.
    always_comb begin
        in_ready  = ~full_s;
        out_valid = ~empty_s | (bypass_en & in_valid);
        count     = count_r;
        if (!empty_s) begin
            out_data = mem_r[rd_ptr_r];
        end else if (bypass_en) begin
            out_data = in_data;
        end else begin
            out_data = {WIDTH{1'b0}};
        end
    end

    // Storage write. Contents do not need a reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Write pointer. It wraps naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
        end else if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Read pointer. It wraps naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {AW{1'b0}};
        end else if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_r <= rd_ptr_r;
        end
    end

    // Occupancy counter. A push and a pop in the same cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= CNT_ZERO;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_mov_buf.sv
// Self-checking bench for mov_buf (WIDTH=8, DEPTH=4).
// The stimulus side pushes every word expected at the output into exp_q.
// A separate monitor pops exp_q and compares it whenever the DUT completes
// an output handshake.
module tb_mov_buf;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             bypass_en;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       count;

    int n_checks = 0;
    int n_pass   = 0;
    int mcount   = 0;
    logic [WIDTH-1:0] exp_q[$];

    mov_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bypass_en (bypass_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    // One cycle of stimulus. Inputs are driven at the negedge and the
    // handshake-side outputs are checked 1 ns later. The expected words are
    // queued, and the model occupancy is advanced for the coming posedge.
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] d,
                         input logic orr, input logic by);
        bit empty, full, thru, push, pop;
        @(negedge clk);
        in_valid = iv; in_data = d; out_ready = orr; bypass_en = by;
        empty = (mcount == 0);
        full  = (mcount == DEPTH);
        thru  = by && empty && iv && orr;
        push  = iv && !full && !thru;
        pop   = !empty && orr;
        #1;
        check("count", int'(count), mcount);
        check("in_ready", int'(in_ready), int'(!full));
        check("out_valid", int'(out_valid), int'(!empty || (by && iv)));
        if (empty && !by) check("out_data_zero", int'(out_data), 0);
        if (thru || push) exp_q.push_back(d);
        mcount = mcount + int'(push) - int'(pop);
    endtask

    // Monitor: compare every completed output handshake with the queue head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", int'(out_data), -1);
                end else begin
                    check("out_data", int'(out_data), int'(exp_q.pop_front()));
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $finish;
    end

    initial begin
        rst = 1'b1; bypass_en = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        check("rst_count", int'(count), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        #20;
        rst = 1'b0;

        // Mid-stream reset with three words stored.
        cycle(1'b1, 8'hA1, 1'b0, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0, 1'b0);
        cycle(1'b1, 8'hA3, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("pre_rst_count", int'(count), 3);
        #1 rst = 1'b1;
        #1;
        check("midrst_count", int'(count), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        exp_q.delete();
        mcount = 0;
        @(negedge clk);
        rst = 1'b0;

        // Fill to full, refuse a fifth word, then drain in order.
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        cycle(1'b1, 8'h44, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        check("full_count", int'(count), 4);
        check("full_in_ready", int'(in_ready), 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("drained_count", int'(count), 0);

        // Wrap: ten pushes with pops delayed by one cycle.
        for (int i = 0; i < 11; i++) begin
            cycle(i < 10, 8'(i), i >= 1, 1'b0);
            check("wrap_count_le2", int'(count <= 3'd2), 1);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("wrap_end_count", int'(count), 0);

        // Simultaneous push and pop at count=2, then pop-only while full.
        cycle(1'b1, 8'h01, 1'b0, 1'b0);
        cycle(1'b1, 8'h02, 1'b0, 1'b0);
        cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("simul_count", int'(count), 2);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("a5_at_head", int'(out_data), 8'hA5);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h66, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("full_pop_only_count", int'(count), 3);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Bypass: same-cycle pass-through, then a stalled bypass word stored.
        cycle(1'b1, 8'h3C, 1'b1, 1'b1);
        check("byp_out_valid", int'(out_valid), 1);
        check("byp_out_data", int'(out_data), 8'h3C);
        cycle(1'b1, 8'h3C, 1'b0, 1'b1);
        check("byp_stall_data", int'(out_data), 8'h3C);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("byp_stored_count", int'(count), 1);
        check("byp_stored_data", int'(out_data), 8'h3C);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end
        while (mcount != 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        #3;
        check("final_queue_empty", exp_q.size(), 0);
        check("final_count", int'(count), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
